// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_arbiter (with helper module adder)
// Brief    : Round-robin arbiter that time-shares one N-bit ripple-carry
//            adder between REQS requesters. It has a single-entry result
//            register that is tagged with the requester index.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder : N-bit ripple-carry adder. It exposes the carry out of every bit.
// ----------------------------------------------------------------------------
module adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic [N-1:0] cout_o
);

    // The carry ripples LSB to MSB. A loop variable keeps the chain acyclic.
    always_comb begin
        logic w_c;
        w_c    = cin_i;
        sum_o  = '0;
        cout_o = '0;
        for (int i = 0; i < N; i++) begin
            sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c;
            w_c       = (a_i[i] & b_i[i]) | (w_c & (a_i[i] ^ b_i[i]));
            cout_o[i] = w_c;
        end
    end

endmodule

// ----------------------------------------------------------------------------
// adder_rr_arbiter : grant, operand mux, shared adder, result register
// ----------------------------------------------------------------------------
module adder_rr_arbiter #(
    parameter int N    = 32,
    parameter int REQS = 4,
    parameter int IDW  = (REQS > 1) ? $clog2(REQS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQS-1:0]   req_valid,
    output logic [REQS-1:0]   req_ready,
    input  logic [REQS*N-1:0] req_a,
    input  logic [REQS*N-1:0] req_b,
    input  logic [REQS-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_ovf,
    output logic [IDW-1:0]    rsp_id
);

    localparam logic [IDW-1:0] c_last_idx = IDW'(REQS - 1);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic           rsp_ovf_q, rsp_ovf_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic           w_can_accept;
    logic           w_found;
    logic [IDW-1:0] w_gnt_idx;
    logic           w_grant;
    logic [IDW-1:0] w_sel;
    logic [N-1:0]   w_a, w_b, w_sum, w_cout;
    logic           w_cin;
    logic           w_unused_cout;

    // A new result may enter when the register is empty or is being drained now.
    assign w_can_accept = !rsp_valid_q || rsp_ready;

    // The search starts at ptr and wraps. It picks the first valid requester.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < REQS; i++) begin
            int j;
            j = int'(ptr_q) + i;
            if (j >= REQS) begin
                j = j - REQS;
            end
            if (!w_found && req_valid[j]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'(j);
            end
        end
    end

    assign w_grant = w_can_accept && w_found && !rst;

    // The grant is one-hot. It is all zero when nothing is accepted.
    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Requester 0 drives the adder on idle cycles. That result is never captured.
    assign w_sel = w_grant ? w_gnt_idx : '0;
    assign w_a   = req_a[int'(w_sel) * N +: N];
    assign w_b   = req_b[int'(w_sel) * N +: N];
    assign w_cin = req_cin[w_sel];

    adder #(
        .N (N)
    ) u_adder (
        .a_i    (w_a),
        .b_i    (w_b),
        .cin_i  (w_cin),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // Only the top two carries are consumed. This folds the rest away.
    assign w_unused_cout = ^w_cout;

    // Next-state logic: capture on accept, otherwise clear on drain, otherwise hold.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_id_d    = rsp_id_q;
        if (w_grant) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = w_sum;
            rsp_cout_d  = w_cout[N-1];
            rsp_ovf_d   = w_cout[N-1] ^ w_cout[N-2];
            rsp_id_d    = w_gnt_idx;
            ptr_d       = (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + IDW'(1);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State register. Reset discards any held result and restarts the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_id    = rsp_id_q;

endmodule

`default_nettype wire

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one instance of the team's `N`-bit ripple-carry `adder` between `REQS` requesters. Each requester presents operands through a valid/ready handshake. The block grants one requester per cycle, drives the shared adder with that requester's operands, and captures sum, carry-out and signed overflow into a single-entry output register. The result is returned on a valid/ready response channel tagged with the requester index. It sits between the datapath's operand sources and the shared adder.

## Interface
- `N`, 32: operand width; passed to the internal `adder` instance; minimum 2.
- `REQS`, 4: number of requesters; minimum 1.
- `IDW`, `$clog2(REQS)` (minimum 1): width of the requester tag.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input `REQS`: bit i set means requester i presents operands.
- `req_ready` output `REQS`: one-hot grant; bit i set means requester i is accepted this cycle.
- `req_a` input `REQS*N`: operand a; requester i occupies bits `[i*N +: N]`.
- `req_b` input `REQS*N`: operand b; same packing as `req_a`.
- `req_cin` input `REQS`: carry-in per requester.
- `rsp_valid` output 1: the output register holds a result.
- `rsp_ready` input 1: the consumer accepts the result.
- `rsp_sum` output `N`: registered sum.
- `rsp_cout` output 1: registered carry out of the MSB (adder `cout[N-1]`).
- `rsp_ovf` output 1: registered signed overflow, `cout[N-1] ^ cout[N-2]`.
- `rsp_id` output `IDW`: index of the requester that produced the result.

## Operation
- **Output register state.** The output register is either EMPTY (`rsp_valid`=0) or FULL (`rsp_valid`=1).
- **Grant enable.** `can_accept = !rsp_valid || rsp_ready`.
- **Grant selection.** When `can_accept` is true and at least one `req_valid` bit is set, grant exactly one requester: the lowest index `g` such that `g >= ptr`, wrapping to the lowest index below `ptr` if none qualifies.
  - `req_ready` is the one-hot of `g`.
  - `req_ready` is all zero when `can_accept` is false or no request is pending.
  - `req_ready` depends combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`.
- **Adder operand mux.** The shared adder inputs are always `req_a`/`req_b`/`req_cin` of `g`. When there is no grant, they are requester 0's inputs; the result is discarded.
- **On accept** (a `req_valid[g]` & `req_ready[g]` handshake):
  - Register `sum`, `cout[N-1]`, `cout[N-1]^cout[N-2]` and `g`.
  - Set `rsp_valid`.
  - Set `ptr` to `(g+1) mod REQS`.
- **On drain without accept** (`rsp_valid` & `rsp_ready` and no grant): clear `rsp_valid`. Data outputs hold their last values.
- **Simultaneous drain and accept:** the new result replaces the old in the same edge and `rsp_valid` stays 1. This gives full throughput.
- **FULL and not drained:**
  - No grant is issued.
  - All `rsp_*` outputs are held stable until the handshake.
  - `ptr` is unchanged.
- **Pointer behaviour.** `ptr` is unchanged on cycles without a grant. Fairness: a continuously requesting requester is granted within `REQS` accepts.
- **`REQS`=1:** `ptr` is constantly 0 and the block degenerates to a one-deep pipeline register.
- **Requester withdrawal.** A requester may drop `req_valid` before it is granted. The block keeps no memory of withdrawn requests.
- **Width rules.** The sum is modulo 2^N. `rsp_cout` is the unsigned carry. `rsp_ovf` is two's-complement overflow.

## Timing
- **Reset values:** `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_ovf`=0, `rsp_id`=0, `ptr`=0.
  - `req_ready` is all zero while `rst`=1.
  - Reset applied mid-operation discards any held result; nothing is replayed.
- **Latency:** a handshake at edge k makes the result visible with `rsp_valid`=1 after edge k. Latency is 1 cycle.
- **Throughput:** one accept per cycle while `rsp_ready`=1.
- **Critical path:** the N-bit ripple chain plus the REQS:1 mux feeding the output register. No internal pipelining.

## Test plan
- **Reset:** hold `rst` 3 cycles with all `req_valid` set → `req_ready`=0 and all `rsp_*`=0 throughout; after release, the first grant goes to requester 0.
- **Single request, N=32:** requester 2 sends a=0xFFFFFFFF, b=0x00000001, cin=0 → one cycle later sum=0, cout=1, ovf=0, id=2. Then a=0x7FFFFFFF, b=1 → sum=0x80000000, cout=0, ovf=1.
- **Round-robin:** all 4 requesters valid, `rsp_ready`=1 → grant order 0,1,2,3,0,1,… one per cycle. Then drop requester 1 → order continues 2,3,0,2,3,0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with a result FULL → `req_ready`=0 and `rsp_*` stable. Raise `rsp_ready` → the drain and the next grant occur on the same edge.
- **Carry-in:** a=5, b=10, cin=1 → sum=16. a=0x80000000, b=0x80000000, cin=0 → sum=0, cout=1, ovf=1.
- **Reset mid-stream:** assert `rst` while FULL with id=3 → `rsp_valid`=0 next cycle; after release, the grant restarts at requester 0 even though `ptr` was at 0 or beyond before reset.
